mux16_arbiter: RTL and testbench
================================

Name: mux16_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 16-bit mux datapath between sources A and B and feeds a single registered output toward a downstream consumer.
- Drives the mux `select` (0 = A, 1 = B).
- Handshakes each source with req/ack and the consumer with valid/ready.
- Caps back-to-back grants to one source when the other is waiting.

Parameters:
- WIDTH, 16, data width of each source and of the output.
- MAX_BURST, 4, maximum consecutive grants to one source while the other source is requesting; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- reqA  input  1  source A has a word on dataA; held until ackA.
- dataA  input  WIDTH  source A word.
- ackA  output  1  A's word is captured this cycle.
- reqB  input  1  source B has a word on dataB; held until ackB.
- dataB  input  WIDTH  source B word.
- ackB  output  1  B's word is captured this cycle.
- select  output  1  current mux select: 0 = A, 1 = B.
- outValid  output  1  outData holds a valid word.
- outData  output  WIDTH  registered output word.
- outReady  input  1  consumer accepts outData this cycle.

Behaviour:
- Reset values:
  - State IDLE, burstCnt 0, lastSel 1 (so A wins the first tie).
  - outValid 0, outData 0, select 0.
  - ackA/ackB forced 0 while reset is high.
- Load condition: `load = !outValid || outReady`. The output register updates only when load is 1.
- State machine: IDLE, GRANT_A, GRANT_B. Grant target each cycle:
  - IDLE:
    - Only reqA → A. Only reqB → B.
    - Both → the source not equal to lastSel.
    - Neither → none.
  - GRANT_A:
    - reqA and not (reqB and burstCnt == MAX_BURST) → A.
    - Otherwise, reqB → B.
    - Otherwise → none.
  - GRANT_B: mirror of GRANT_A.
- select is combinational from the target: A → 0, B → 1. With no target, select holds its last value.
- Acknowledge:
  - ackX = load && target == X && reqX && !reset.
  - At most one ack is high per cycle.
- On an ack (rising edge):
  - outData ← mux(select, dataA, dataB); outValid ← 1.
  - State ← GRANT_target; lastSel ← target.
  - burstCnt ← 1 on a source switch or from IDLE; otherwise burstCnt + 1, saturating at MAX_BURST.
- Load with no ack:
  - outValid ← 0 if outReady consumed the word, else it stays.
  - State ← IDLE; burstCnt ← 0.
- No load (outValid && !outReady):
  - outData, outValid and state hold.
  - No ack is issued; sources stall.
- Latency:
  - Request to ack: 0 cycles when load = 1.
  - Ack to outValid: 1 cycle.
  - Full throughput: one word per cycle while outReady stays high.
- Both sources requesting, outReady constantly 1: grant pattern is MAX_BURST words from one source, then MAX_BURST from the other, repeating.
- A source dropping req mid-burst hands over immediately, the same cycle.
- Reset mid-transfer: the pending output word is discarded and outValid drops asynchronously.

Optional Feature:
- Macro: MUX16_ARBITER_STATS_EN.
- When defined:
  - Adds outputs grantCountA[15:0] and grantCountB[15:0]: per-source accepted-word counters.
  - Counters increment on ackA/ackB and saturate at 16'hFFFF.
  - Both reset to 0.
- When undefined: the ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Shared defines header mux16_arbiter_defs.vh holds:
  - State encodings: IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2.
  - Select constants: SEL_A = 0, SEL_B = 1.
- One sub-module: the existing Mux16bit instance performs the data selection (select → inA/inB). The arbiter contains only control and registers.

Test Plan:
- Reset hold then release, no reqs → outValid = 0, ackA = ackB = 0, select = 0 for 5 cycles.
- reqA with dataA = 16'h1234, outReady = 1 → ackA in the same cycle; outValid = 1 and outData = 16'h1234 next cycle; select = 0.
- reqA and reqB both held, dataA = 16'hAAAA, dataB = 16'h5555, outReady = 1, MAX_BURST = 4 → output sequence 4×AAAA, 4×5555, 4×AAAA; no idle bubbles.
- outReady = 0 with outValid = 1, reqB held → ackB stays 0, outData is stable. On outReady = 1, ackB fires in that same cycle.
- Reset asserted mid-burst, in the cycle after an ack → outValid is 0 immediately, with no clock edge. After release, a tie grants A first.
- With MUX16_ARBITER_STATS_EN defined: 3 A-words and 5 B-words accepted → grantCountA = 3, grantCountB = 5.

Source files
------------

// File: rtl/mux16_arbiter_pkg.sv
// Shared types and constants for the mux16_arbiter block: FSM state
// encoding, mux select constants and a saturating counter helper.
package mux16_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Increment a burst counter, sticking at the supplied ceiling.
  function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic [3:0] ceil);
    return (cnt >= ceil) ? ceil : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/mux16_arbiter_mux.sv
// Two-input word multiplexer shared by both sources: sel 0 picks A, 1 picks B.
module mux16_arbiter_mux #(
  parameter int WIDTH = 16
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_sel ? i_in_b : i_in_a;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter sharing one word mux between sources A and B, with a
// registered valid/ready output stage and a cap on consecutive grants to one
// source while the other waits. Optional per-source accepted-word counters
// are built when MUX16_ARBITER_STATS_EN is defined.
module mux16_arbiter
  import mux16_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic [WIDTH-1:0] dataA,
  output logic             ackA,
  input  logic             reqB,
  input  logic [WIDTH-1:0] dataB,
  output logic             ackB,
  output logic             select,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
`ifdef MUX16_ARBITER_STATS_EN
  ,
  output logic [15:0]      grantCountA,
  output logic [15:0]      grantCountB
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t           r_state;
  logic [3:0]       r_burst_cnt;
  logic             r_last_sel;
  logic             r_sel;
  logic             r_out_vld_p1;
  logic [WIDTH-1:0] r_out_data_p1;

  logic             w_load;
  logic             w_tgt_vld;
  logic             w_tgt_sel;
  logic             w_select;
  logic             w_ack_a;
  logic             w_ack_b;
  logic             w_ack;
  logic             w_same_src;
  logic [WIDTH-1:0] w_mux_data;

  assign w_load = !r_out_vld_p1 || outReady;

  // Pick this cycle's grant target from the current owner and the burst cap.
  always_comb begin
    w_tgt_vld = 1'b0;
    w_tgt_sel = SEL_A;
    case (r_state)
      ST_GRANT_A: begin
        if (reqA && !(reqB && r_burst_cnt == MAX_B)) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = SEL_A;
        end else if (reqB) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = SEL_B;
        end
      end
      ST_GRANT_B: begin
        if (reqB && !(reqA && r_burst_cnt == MAX_B)) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = SEL_B;
        end else if (reqA) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = SEL_A;
        end
      end
      default: begin
        if (reqA && reqB) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = ~r_last_sel;
        end else if (reqA) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = SEL_A;
        end else if (reqB) begin
          w_tgt_vld = 1'b1;
          w_tgt_sel = SEL_B;
        end
      end
    endcase
  end

  // With no target the mux keeps pointing where it last pointed.
  assign w_select   = w_tgt_vld ? w_tgt_sel : r_sel;
  assign w_ack_a    = w_load && w_tgt_vld && (w_tgt_sel == SEL_A) && reqA && !reset;
  assign w_ack_b    = w_load && w_tgt_vld && (w_tgt_sel == SEL_B) && reqB && !reset;
  assign w_ack      = w_ack_a || w_ack_b;
  assign w_same_src = ((w_tgt_sel == SEL_A) && (r_state == ST_GRANT_A)) ||
                      ((w_tgt_sel == SEL_B) && (r_state == ST_GRANT_B));

  mux16_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
    .i_sel  (w_select),
    .i_in_a (dataA),
    .i_in_b (dataB),
    .o_out  (w_mux_data)
  );

  // Arbitration state: owner, run length, tie-break history and held select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= 4'd0;
      r_last_sel  <= SEL_B;
      r_sel       <= SEL_A;
    end else begin
      r_sel <= w_select;
      if (w_ack) begin
        r_state     <= (w_tgt_sel == SEL_A) ? ST_GRANT_A : ST_GRANT_B;
        r_last_sel  <= w_tgt_sel;
        r_burst_cnt <= w_same_src ? sat_inc4(r_burst_cnt, MAX_B) : 4'd1;
      end else if (w_load) begin
        r_state     <= ST_IDLE;
        r_burst_cnt <= 4'd0;
      end
    end
  end

  // ---- stage p1: registered output word toward the consumer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_vld_p1  <= 1'b0;
      r_out_data_p1 <= '0;
    end else if (w_ack) begin
      r_out_vld_p1  <= 1'b1;
      r_out_data_p1 <= w_mux_data;
    end else if (w_load) begin
      r_out_vld_p1  <= 1'b0;
    end
  end

`ifdef MUX16_ARBITER_STATS_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  // Count accepted words per source, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_a <= 16'd0;
      r_cnt_b <= 16'd0;
    end else begin
      if (w_ack_a && r_cnt_a != 16'hFFFF) r_cnt_a <= r_cnt_a + 16'd1;
      if (w_ack_b && r_cnt_b != 16'hFFFF) r_cnt_b <= r_cnt_b + 16'd1;
    end
  end

  assign grantCountA = r_cnt_a;
  assign grantCountB = r_cnt_b;
`endif

  assign ackA     = w_ack_a;
  assign ackB     = w_ack_b;
  assign select   = w_select;
  assign outValid = r_out_vld_p1;
  assign outData  = r_out_data_p1;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Directed plus randomized bench for mux16_arbiter against a behavioural
// owner/run-length reference model.
module tb_mux16_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqA, reqB, outReady;
  logic [15:0] dataA, dataB;
  logic        ackA, ackB, select, outValid;
  logic [15:0] outData;
`ifdef MUX16_ARBITER_STATS_EN
  logic [15:0] grantCountA, grantCountB;
`endif

  mux16_arbiter #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqA     (reqA),
    .dataA    (dataA),
    .ackA     (ackA),
    .reqB     (reqB),
    .dataB    (dataB),
    .ackB     (ackB),
    .select   (select),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData)
`ifdef MUX16_ARBITER_STATS_EN
    ,
    .grantCountA (grantCountA),
    .grantCountB (grantCountB)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the mux, how many words in a row it has had,
  // who won last, where the mux points, and the output register contents.
  int          m_owner;
  int          m_run;
  int          m_last;
  int          m_sel;
  int          m_vld;
  logic [15:0] m_data;
  int          m_tgt;
  int          m_load;
  int          m_cnt_a, m_cnt_b;
  logic        s_ackA, s_ackB;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1; m_sel = 0;
    m_vld = 0; m_data = 16'h0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_comb();
    int mine, other;
    m_load = (m_vld == 0 || outReady) ? 1 : 0;
    m_tgt  = -1;
    if (m_owner < 0) begin
      if (reqA && reqB) m_tgt = 1 - m_last;
      else if (reqA)    m_tgt = 0;
      else if (reqB)    m_tgt = 1;
    end else begin
      mine  = (m_owner == 0) ? int'(reqA) : int'(reqB);
      other = (m_owner == 0) ? int'(reqB) : int'(reqA);
      if (mine != 0 && !(other != 0 && m_run == MAXB)) m_tgt = m_owner;
      else if (other != 0) m_tgt = 1 - m_owner;
    end
  endtask

  task automatic model_commit();
    if (m_tgt >= 0) m_sel = m_tgt;
    if (m_load != 0 && m_tgt >= 0) begin
      m_data = (m_tgt == 1) ? dataB : dataA;
      m_vld  = 1;
      m_run  = (m_owner == m_tgt) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
      m_owner = m_tgt;
      m_last  = m_tgt;
      if (m_tgt == 0) m_cnt_a++; else m_cnt_b++;
    end else if (m_load != 0) begin
      m_vld = 0; m_owner = -1; m_run = 0;
    end
  endtask

  // One clock: inputs are already set at posedge+1; check handshake outputs
  // mid-cycle, then the registered outputs just after the next edge.
  task automatic step();
    #2;
    model_comb();
    s_ackA = ackA;
    s_ackB = ackB;
    chk("ackA", 32'(ackA), 32'(m_load != 0 && m_tgt == 0));
    chk("ackB", 32'(ackB), 32'(m_load != 0 && m_tgt == 1));
    chk("select", 32'(select), 32'((m_tgt >= 0) ? m_tgt : m_sel));
    @(posedge clk);
    model_commit();
    #1;
    chk("outValid", 32'(outValid), 32'(m_vld));
    chk("outData", 32'(outData), 32'(m_data));
  endtask

  initial begin
    reset = 1'b1; reqA = 1'b0; reqB = 1'b0; outReady = 1'b0;
    dataA = 16'h0; dataB = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(outValid), 32'd0);
    chk("rst_data", 32'(outData), 32'd0);
    chk("rst_sel", 32'(select), 32'd0);
    chk("rst_acks", 32'({ackA, ackB}), 32'd0);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_vld", 32'(outValid), 32'd0);
      chk("idle_sel", 32'(select), 32'd0);
    end

    // Single A word.
    reqA = 1'b1; dataA = 16'h1234; outReady = 1'b1;
    step();
    chk("single_ackA", 32'(s_ackA), 32'd1);
    chk("single_vld", 32'(outValid), 32'd1);
    chk("single_data", 32'(outData), 32'h1234);
    reqA = 1'b0;
    step();

    // Consumer stall with B waiting.
    reqB = 1'b1; dataB = 16'hBEEF;
    step();
    chk("stall_first", 32'(s_ackB), 32'd1);
    outReady = 1'b0; dataB = 16'hC0DE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ackB", 32'(s_ackB), 32'd0);
      chk("stall_data", 32'(outData), 32'hBEEF);
    end
    outReady = 1'b1;
    step();
    chk("unstall_ackB", 32'(s_ackB), 32'd1);
    chk("unstall_data", 32'(outData), 32'hC0DE);
    reqB = 1'b0;
    step();

    // Reset landing in the cycle after an ack.
    reqA = 1'b1; dataA = 16'h7777;
    step();
    chk("pre_rst_vld", 32'(outValid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_vld", 32'(outValid), 32'd0);
    chk("async_rst_ack", 32'(ackA), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Both held: bursts of MAXB alternating, A first after reset.
    reqA = 1'b1; dataA = 16'hAAAA; reqB = 1'b1; dataB = 16'h5555;
    for (int i = 0; i < 3 * MAXB; i++) begin
      step();
      chk("burst_ackA", 32'(s_ackA), 32'(((i / MAXB) % 2) == 0));
      chk("burst_data", 32'(outData), ((i / MAXB) % 2 == 0) ? 32'hAAAA : 32'h5555);
    end
    reqA = 1'b0; reqB = 1'b0;
    step();

    // Randomized sources and consumer.
    begin
      bit pa, pb;
      pa = 1'b0; pb = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if (!pa && ($urandom % 3) != 0) begin pa = 1'b1; dataA = 16'($urandom); end
        if (!pb && ($urandom % 3) != 0) begin pb = 1'b1; dataB = 16'($urandom); end
        reqA = pa; reqB = pb;
        outReady = (($urandom % 4) != 0);
        step();
        if (m_load != 0 && m_tgt == 0) pa = 1'b0;
        if (m_load != 0 && m_tgt == 1) pb = 1'b0;
      end
    end

`ifdef MUX16_ARBITER_STATS_EN
    chk("grantCountA", 32'(grantCountA), 32'(m_cnt_a));
    chk("grantCountB", 32'(grantCountB), 32'(m_cnt_b));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
